memaccess_seq: RTL



---
 rtl/memaccess_seq.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/memaccess_seq.sv
// -----------------------------------------------------------------------------
// memaccess_seq
//
// Controller slice that sequences data-memory accesses for the LC3 MemAccess
// stage. It decodes the memory opcode and drives the 2-bit mem_state select
// that MemAccess consumes. It waits for dmem_ack on every access and walks
// LDI/STI through their extra indirection phase. When the access ends it
// reports completion and, for loads, a writeback enable.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   access request; only looked at in IDLE
//   opcode[3:0]  in   IR[15:12]; sampled together with start
//   dmem_ack     in   memory finished the current access this cycle
//   mem_state    out  MemAccess select: 00 RD, 01 IND, 10 WR, 11 IDLE
//   busy         out  high in any state other than IDLE
//   ind_ld       out  one-cycle pulse: latch the indirect address from memout
//   done         out  one-cycle completion pulse (success or timeout)
//   wb_en        out  one-cycle pulse with done, for successful loads only
//   err_timeout  out  sticky abort flag; cleared by the next accepted start
//
// Parameters:
//   ACK_TIMEOUT  most cycles to wait for dmem_ack in one access state
//                (1..255, and below 2**TO_W)
//   TO_W         width of the wait counter
//
// Build option:
//   MEMSEQ_ZERO_WAIT_EN  When defined, dmem_ack is ignored and every access
//                        state lasts exactly one cycle. The timeout path can
//                        never fire, so err_timeout stays 0.
//
// Every output comes from a flop. mem_state is the state register itself,
// because the state encoding matches the select code MemAccess expects.
// -----------------------------------------------------------------------------
module memaccess_seq #(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned TO_W        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic       dmem_ack,
  output logic [1:0] mem_state,
  output logic       busy,
  output logic       ind_ld,
  output logic       done,
  output logic       wb_en,
  output logic       err_timeout
);

  // The state codes are the MemAccess select codes, so mem_state needs no
  // decode logic.
  typedef enum logic [1:0] {
    ST_RD   = 2'b00,
    ST_IND  = 2'b01,
    ST_WR   = 2'b10,
    ST_IDLE = 2'b11
  } state_t;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

  state_t          state, state_nx;
  logic [TO_W-1:0] wait_cnt, wait_cnt_nx;
  logic            is_load, is_load_nx;
  logic            busy_nx, ind_ld_nx, done_nx, wb_en_nx, err_nx;

  // Opcode decode.
  state_t dec_state;
  logic   dec_valid;
  logic   dec_load;

  // Qualified acknowledge and timeout condition. The build option selects
  // how these are produced.
  logic acc_ack;
  logic timeout_hit;

`ifdef MEMSEQ_ZERO_WAIT_EN
  // Every access state is treated as acknowledged in its first cycle.
  // Because of that, the wait counter never advances and the timeout
  // branch cannot be reached.
  logic unused_ack;
  assign unused_ack  = dmem_ack;
  assign acc_ack     = 1'b1;
  assign timeout_hit = 1'b0;
`else
  assign acc_ack     = dmem_ack;
  // The timeout fires on the last allowed wait cycle. The counter therefore
  // stops there and never wraps.
  assign timeout_hit = (wait_cnt == CNT_LAST);
`endif

  // ---------------------------------------------------------------------------
  // Opcode decode. Non-memory opcodes are marked invalid, and start ignores them.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path is left holding a value (which would infer a latch).
    dec_state = ST_IDLE;
    dec_valid = 1'b1;
    dec_load  = 1'b0;
    case (opcode)
      OP_LD, OP_LDR: begin
        dec_state = ST_RD;
        dec_load  = 1'b1;
      end
      OP_ST, OP_STR: begin
        dec_state = ST_WR;
      end
      OP_LDI: begin
        dec_state = ST_IND;
        dec_load  = 1'b1;
      end
      OP_STI: begin
        dec_state = ST_IND;
      end
      default: begin
        dec_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    is_load_nx  = is_load;
    ind_ld_nx   = 1'b0;
    done_nx     = 1'b0;
    wb_en_nx    = 1'b0;
    err_nx      = err_timeout;

    case (state)
      ST_IDLE: begin
        // dmem_ack is ignored here. A start raised in the same cycle that
        // done is high lands in this branch and is accepted normally.
        if (start && dec_valid) begin
          state_nx    = dec_state;
          is_load_nx  = dec_load;
          wait_cnt_nx = '0;
          err_nx      = 1'b0;
        end
      end

      ST_IND: begin
        if (acc_ack) begin
          // The indirect pointer is now on memout. Go to the data phase.
          // is_load tells LDI (read) apart from STI (write).
          state_nx    = is_load ? ST_RD : ST_WR;
          ind_ld_nx   = 1'b1;
          wait_cnt_nx = '0;
        end else if (timeout_hit) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          err_nx   = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + CNT_ONE;
        end
      end

      default: begin  // ST_RD, ST_WR
        if (acc_ack) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          wb_en_nx = is_load;
        end else if (timeout_hit) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          err_nx   = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + CNT_ONE;
        end
      end
    endcase

    busy_nx = (state_nx != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers. When reset is asserted during an access, the
  // access is dropped at once and no done is issued.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. All flops then
  // update together from values sampled before the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      is_load     <= 1'b0;
      busy        <= 1'b0;
      ind_ld      <= 1'b0;
      done        <= 1'b0;
      wb_en       <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_cnt_nx;
      is_load     <= is_load_nx;
      busy        <= busy_nx;
      ind_ld      <= ind_ld_nx;
      done        <= done_nx;
      wb_en       <= wb_en_nx;
      err_timeout <= err_nx;
    end
  end

  assign mem_state = state;

endmodule
